// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, opcode field and fetch FSM states.
// Reused by fetch and decode stages.
package cpu_pkg;

    localparam int XLEN = 19;

    // Opcode lives in the top four bits of the instruction word.
    localparam int OP_MSB = 18;
    localparam int OP_LSB = 15;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_halt_op(input logic [OP_W-1:0] op);
        return op == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH-entry FIFO of {pc, instr}; head is a register read.
// Ports: push/push_data, pop, flush, head, count, full, empty.
module fetch_queue #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // DEPTH is a power of two, so pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: PC register, RUN/HALT FSM and fetch queue toward decode.
// Ports: imem_addr/imem_instr, out_* handshake, redirect, resume, halted.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int               XLEN     = cpu_pkg::XLEN,
    parameter int               QDEPTH   = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            resume,
    output logic            halted
);

    fetch_state_t state, state_nxt;

    logic [XLEN-1:0]          pc, pc_nxt;
    logic                     push, pop, take, space;
    logic [2*XLEN-1:0]        head;
    logic [$clog2(QDEPTH):0]  count;
    logic                     full, empty;

    fetch_queue #(
        .W     (2*XLEN),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({pc, imem_instr}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    assign take   = out_valid && out_ready;
    // A full queue still has room when the head leaves this cycle.
    assign space  = !full || take;
    // Flush on redirect wins; the popped head is simply dropped with the rest.
    assign pop    = take;
    assign halted = (state == ST_HALT) && empty;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        if (redirect_valid) begin
            state_nxt = ST_RUN;
            pc_nxt    = redirect_pc;
        end else begin
            case (state)
                ST_RUN: begin
                    if (space) begin
                        push   = 1'b1;
                        pc_nxt = pc + 1'b1;
                        if (is_halt_op(imem_instr[XLEN-1 -: OP_W])) begin
                            state_nxt = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume && halted) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_pc    = head[2*XLEN-1:XLEN];
    assign out_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected fetch PCs.
// Memory model: halt word at halt_addr when enabled, else {4'h1, addr}.
module tb_fetch_ctrl;

    localparam int XLEN = 19;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_ready = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            resume = 1'b0;
    logic            halted;

    logic            halt_en = 1'b1;
    logic [XLEN-1:0] halt_addr = 19'd5;

    int passed = 0;
    int total  = 0;

    logic [XLEN-1:0] sb [$];

    fetch_ctrl #(
        .XLEN     (XLEN),
        .QDEPTH   (2),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resume         (resume),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a,
                                                 input logic en,
                                                 input logic [XLEN-1:0] ha);
        if (en && a == ha) return 19'h78000;
        return {4'h1, a[14:0]};
    endfunction

    assign imem_instr = mem_word(imem_addr, halt_en, halt_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_pcs(input logic [XLEN-1:0] first, input int n);
        logic [XLEN-1:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            sb.push_back(a);
            a = a + 1'b1;
        end
    endtask

    // Called at a falling edge with inputs already driven; scores any
    // transfer that the next rising edge will complete.
    task automatic step();
        logic [XLEN-1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {13'd0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_pc", {13'd0, out_pc}, {13'd0, e});
                chk("out_instr", {13'd0, out_instr},
                    {13'd0, mem_word(e, halt_en, halt_addr)});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instr", {13'd0, out_instr}, 32'd0);
        chk("rst_pc", {13'd0, out_pc}, 32'd0);
        chk("rst_addr", {13'd0, imem_addr}, 32'd0);

        // Demo program: 0..5 stream, halt at 5.
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_pcs(0, 6);
        step();
        drain(6);
        chk("demo_halted", {31'd0, halted}, 32'd1);
        chk("demo_addr", {13'd0, imem_addr}, 32'd6);
        chk("demo_sb", sb.size(), 32'd0);
        step();
        chk("halt_idle", {31'd0, out_valid}, 32'd0);
        chk("halt_addr_hold", {13'd0, imem_addr}, 32'd6);

        // Resume from 6.
        resume = 1'b1;
        step();
        resume = 1'b0;
        halt_en = 1'b0;
        expect_pcs(6, 2);
        step();
        drain(2);
        chk("resume_sb", sb.size(), 32'd0);

        // Redirect to the halt word, then redirect to 0 while halted.
        out_ready = 1'b0;
        halt_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 19'd5;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        expect_pcs(5, 1);
        step();
        drain(1);
        chk("halt2_halted", {31'd0, halted}, 32'd1);
        chk("halt2_addr", {13'd0, imem_addr}, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc = 19'd0;
        step();
        redirect_valid = 1'b0;
        chk("redir_halt_exit", {31'd0, halted}, 32'd0);
        expect_pcs(0, 3);
        step();
        drain(3);
        chk("redir0_sb", sb.size(), 32'd0);

        // Backpressure from reset, then redirect on a full queue.
        rst_n = 1'b0;
        out_ready = 1'b0;
        halt_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("full_addr", {13'd0, imem_addr}, 32'd2);
        chk("full_head", {13'd0, out_pc}, 32'd0);
        step();
        chk("full_addr_hold", {13'd0, imem_addr}, 32'd2);
        chk("full_head_hold", {13'd0, out_pc}, 32'd0);
        chk("full_instr_hold", {13'd0, out_instr}, 32'h0800_0);
        redirect_valid = 1'b1;
        redirect_pc = 19'd3;
        step();
        redirect_valid = 1'b0;
        chk("flush_empty", {31'd0, out_valid}, 32'd0);
        step();
        chk("redir_valid", {31'd0, out_valid}, 32'd1);
        chk("redir_pc", {13'd0, out_pc}, 32'd3);
        out_ready = 1'b1;
        expect_pcs(3, 3);
        drain(3);
        chk("redir3_sb", sb.size(), 32'd0);

        // Backpressure release: heads 0,1,2 back to back.
        rst_n = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        out_ready = 1'b1;
        expect_pcs(0, 3);
        drain(3);
        chk("bp_sb", sb.size(), 32'd0);

        // PC wrap.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 19'h7FFFF;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        expect_pcs(19'h7FFFF, 3);
        step();
        drain(3);
        chk("wrap_sb", sb.size(), 32'd0);

        // Asynchronous reset with two queued entries.
        out_ready = 1'b0;
        step();
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_addr", {13'd0, imem_addr}, 32'd0);
        chk("async_pc", {13'd0, out_pc}, 32'd0);
        chk("async_instr", {13'd0, out_instr}, 32'd0);
        chk("async_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_pcs(0, 3);
        step();
        drain(3);
        chk("final_sb", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
